// File: rtl/axis_dma_ingress_fifo.sv
// DMA MM2S ingress buffer: wide-word FIFO plus a hold register that
// serializes each word, low lane first, into narrow model-side beats.
module axis_dma_ingress_fifo #(
    parameter int DEPTH          = 8,
    parameter int IN_DATA_WIDTH  = 32,
    parameter int OUT_DATA_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    input  logic [IN_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [IN_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic                       m_axis_tvalid,
    output logic [OUT_DATA_WIDTH-1:0]  m_axis_tdata,
    input  logic                       m_axis_tready,
    output logic                       frame_done,
    output logic [31:0]                frame_beats,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int LANES  = IN_DATA_WIDTH / OUT_DATA_WIDTH;
    localparam int KEEP_W = IN_DATA_WIDTH / 8;
    localparam int KPL    = OUT_DATA_WIDTH / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = $clog2(LANES + 1);
    localparam int IW     = (LANES > 1) ? $clog2(LANES) : 1;

    logic [IN_DATA_WIDTH-1:0] r_mem_data [DEPTH];
    logic [LW-1:0]            r_mem_nl   [DEPTH];
    logic                     r_mem_last [DEPTH];

    logic [AW:0]              r_wr_ptr;
    logic [AW:0]              r_rd_ptr;

    logic                     r_hold_v;
    logic [IN_DATA_WIDTH-1:0] r_data;
    logic [LW-1:0]            r_nlanes;
    logic                     r_last;
    logic [IW-1:0]            r_lane;
    logic [31:0]              r_beat_cnt;

    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_hs;
    logic          w_lane_last;
    logic          w_final;
    logic          w_load;
    logic [LW-1:0] w_nlanes;

    // A lane counts as present only when every byte enable inside it is set.
    always_comb begin
        w_nlanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (&s_axis_tkeep[k*KPL +: KPL]) begin
                w_nlanes = w_nlanes + LW'(1);
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_en = s_axis_tvalid & ~w_full;

    assign w_hs        = r_hold_v & m_axis_tready;
    assign w_lane_last = (LW'(r_lane) + LW'(1)) >= r_nlanes;
    assign w_final     = w_hs & w_lane_last;
    assign w_load      = ~w_empty & (~r_hold_v | w_final);

    assign s_axis_tready = ~w_full;
    assign m_axis_tvalid = r_hold_v;
    assign m_axis_tdata  = r_data[r_lane*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
    assign frame_done    = w_final & r_last;
    assign frame_beats   = r_beat_cnt + 32'(w_hs);
    assign occupancy     = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem_data[r_wr_ptr[AW-1:0]] <= s_axis_tdata;
            r_mem_nl[r_wr_ptr[AW-1:0]]   <= w_nlanes;
            r_mem_last[r_wr_ptr[AW-1:0]] <= s_axis_tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Loading on the final-lane handshake keeps the narrow side bubble-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_v <= 1'b0;
            r_data   <= '0;
            r_nlanes <= '0;
            r_last   <= 1'b0;
            r_lane   <= '0;
        end else if (w_load) begin
            r_hold_v <= 1'b1;
            r_data   <= r_mem_data[r_rd_ptr[AW-1:0]];
            r_nlanes <= r_mem_nl[r_rd_ptr[AW-1:0]];
            r_last   <= r_mem_last[r_rd_ptr[AW-1:0]];
            r_lane   <= '0;
        end else if (w_hs) begin
            if (w_lane_last) begin
                r_hold_v <= 1'b0;
            end else begin
                r_lane <= r_lane + IW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (frame_done) begin
            r_beat_cnt <= '0;
        end else if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_dma_ingress_fifo.sv
// Bench for axis_dma_ingress_fifo: vector table, scoreboard of expected
// narrow beats, and hand sequences for backpressure, wrap and reset.
module tb_axis_dma_ingress_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = '0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tready;
    logic        frame_done;
    logic [31:0] frame_beats;
    logic [3:0]  occ;

    logic man_rdy = 1'b0;
    logic rnd_rdy = 1'b0;
    int   rmode = 0;

    assign m_tready = (rmode == 2) ? rnd_rdy : man_rdy;

    axis_dma_ingress_fifo #(
        .DEPTH(8),
        .IN_DATA_WIDTH(32),
        .OUT_DATA_WIDTH(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tdata(s_tdata),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tdata(m_tdata),
        .m_axis_tready(m_tready),
        .frame_done(frame_done),
        .frame_beats(frame_beats),
        .occupancy(occ)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #2;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [7:0]  d;
        logic        fd;
        logic [31:0] beats;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          nl;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tbl[5];
    int   total = 0;
    int   bad = 0;
    int   fd_cnt = 0;
    int   hs_cnt = 0;
    int   fb = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] d, input int nl,
                            input logic l);
        exp_t e;
        for (int k = 0; k < nl; k++) begin
            fb++;
            e.d = d[k*8 +: 8];
            e.fd = l && (k == nl - 1);
            e.beats = 32'(fb);
            sb.push_back(e);
            if (e.fd) fb = 0;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k,
                        input logic l, input int nl);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata = d;
        s_tkeep = k;
        s_tlast = l;
        while (!s_tready && n < 500) begin
            tick();
            n++;
        end
        if (!s_tready) begin
            chk("send_timeout", 32'(s_tready), 32'd1);
            s_tvalid = 1'b0;
            return;
        end
        push_exp(d, nl, l);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (m_tvalid && m_tready) begin
                hs_cnt++;
                if (frame_done) fd_cnt++;
                if (sb.size() == 0) begin
                    chk("extra_beat", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    chk("beat_data", 32'(m_tdata), 32'(mon_e.d));
                    chk("beat_fd", 32'(frame_done), 32'(mon_e.fd));
                    chk("beat_cnt", frame_beats, mon_e.beats);
                end
            end else if (frame_done) begin
                chk("fd_no_hs", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        int  fd0;
        int  base;
        logic rose;
        logic [31:0] d;

        tbl[0] = '{32'h4433_2211, 4'hF, 1'b1, 4};
        tbl[1] = '{32'hAABB_CCDD, 4'hF, 1'b0, 4};
        tbl[2] = '{32'h0000_0605, 4'h3, 1'b1, 2};
        tbl[3] = '{32'h1234_5678, 4'h1, 1'b1, 1};
        tbl[4] = '{32'hCAFE_F00D, 4'h7, 1'b1, 3};

        // reset with a valid beat presented
        s_tvalid = 1'b1;
        s_tdata = 32'hDEAD_BEEF;
        s_tkeep = 4'hF;
        s_tlast = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_tready", 32'(s_tready), 32'd1);
            chk("rst_mvalid", 32'(m_tvalid), 32'd0);
            chk("rst_occ", 32'(occ), 32'd0);
            chk("rst_tdata", 32'(m_tdata), 32'd0);
            chk("rst_fd", 32'(frame_done), 32'd0);
            chk("rst_beats", frame_beats, 32'd0);
        end
        rst = 1'b0;
        s_tvalid = 1'b0;
        tick();
        chk("idle_occ", 32'(occ), 32'd0);
        chk("idle_mvalid", 32'(m_tvalid), 32'd0);

        // serialization latency
        rmode = 0;
        man_rdy = 1'b1;
        send(32'h4433_2211, 4'hF, 1'b1, 4);
        chk("lat_wr_edge", 32'(m_tvalid), 32'd0);
        tick();
        chk("lat_load", 32'(m_tvalid), 32'd1);
        drain();

        // partial last beat, no bubble between words
        fd0 = fd_cnt;
        send(32'hAABB_CCDD, 4'hF, 1'b0, 4);
        send(32'h0000_0605, 4'h3, 1'b1, 2);
        repeat (6) begin
            chk("no_bubble", 32'(m_tvalid), 32'd1);
            tick();
        end
        chk("partial_fd", 32'(fd_cnt - fd0), 32'd1);
        drain();

        for (int i = 0; i < 5; i++) begin
            send(tbl[i].d, tbl[i].k, tbl[i].l, tbl[i].nl);
        end
        drain();

        // full and backpressure
        man_rdy = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < 4; j++) d[j*8 +: 8] = 8'(i * 4 + j);
            send(d, 4'hF, (i == 8), 4);
        end
        chk("full_tready", 32'(s_tready), 32'd0);
        chk("full_occ", 32'(occ), 32'd8);
        chk("full_mvalid", 32'(m_tvalid), 32'd1);
        base = hs_cnt;
        rose = 1'b0;
        man_rdy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (hs_cnt - base < 4) begin
                chk("full_hold", 32'(s_tready), 32'd0);
            end else begin
                chk("tready_rise", 32'(s_tready), 32'd1);
                chk("occ_after_load", 32'(occ), 32'd7);
                rose = 1'b1;
                break;
            end
        end
        chk("tready_rose", 32'(rose), 32'd1);
        drain();

        // pointer wrap with random stalls
        fd0 = fd_cnt;
        rmode = 2;
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < 5; w++) begin
                send($urandom, 4'hF, (w == 4), 4);
            end
        end
        drain();
        rmode = 0;
        chk("wrap_fd_cnt", 32'(fd_cnt - fd0), 32'd3);

        // reset in the middle of a frame
        man_rdy = 1'b0;
        fd0 = fd_cnt;
        send(32'h0403_0201, 4'hF, 1'b1, 4);
        tick();
        chk("mid_loaded", 32'(m_tvalid), 32'd1);
        base = hs_cnt;
        man_rdy = 1'b1;
        tick();
        tick();
        man_rdy = 1'b0;
        chk("mid_two_beats", 32'(hs_cnt - base), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        fb = 0;
        chk("mid_mvalid", 32'(m_tvalid), 32'd0);
        chk("mid_fd", 32'(frame_done), 32'd0);
        chk("mid_beats", frame_beats, 32'd0);
        chk("mid_occ", 32'(occ), 32'd0);
        chk("mid_no_fd", 32'(fd_cnt - fd0), 32'd0);
        man_rdy = 1'b1;
        send(32'h0D0C_0B0A, 4'hF, 1'b1, 4);
        drain();
        chk("post_rst_fd", 32'(fd_cnt - fd0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_dma_ingress_fifo.md
# axis_dma_ingress_fifo

Ingress buffer between the DMA MM2S AXI-Stream master and the FINN stitched-IP slave input. It accepts wide DMA beats with TKEEP/TLAST into a word FIFO and serializes each beat, least-significant lane first, into narrow beats for the model. The model-side interface carries no TLAST. Frame boundaries are reported on a sideband pulse and a beat counter instead.

## Interface

Parameters:
- DEPTH, 8: FIFO depth in IN-width words; power of two, ≥2
- IN_DATA_WIDTH, 32: DMA-side data width; multiple of OUT_DATA_WIDTH
- OUT_DATA_WIDTH, 8: model-side data width; multiple of 8
- LANES (derived), IN_DATA_WIDTH/OUT_DATA_WIDTH: lanes per word
- KEEP_W (derived), IN_DATA_WIDTH/8: TKEEP width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- s_axis_tvalid  in  1  DMA beat valid
- s_axis_tdata  in  IN_DATA_WIDTH  DMA beat data
- s_axis_tkeep  in  KEEP_W  byte enables; low-aligned and contiguous
- s_axis_tlast  in  1  last beat of DMA transfer
- s_axis_tready  out  1  FIFO not full
- m_axis_tvalid  out  1  model beat valid
- m_axis_tdata  out  OUT_DATA_WIDTH  current lane
- m_axis_tready  in  1  model ready
- frame_done  out  1  one-cycle pulse on the handshake of the final lane of a TLAST word
- frame_beats  out  32  count of narrow beats in the current frame, including the one now handshaking
- occupancy  out  $clog2(DEPTH)+1  words held in the FIFO, excluding the hold register

## Operation

- FIFO entry format: {tlast, nlanes, tdata}.
  - nlanes is the number of lanes whose TKEEP bits are all 1, range 1..LANES.
  - It is computed at write time.
- Write pointer and read pointer are each $clog2(DEPTH)+1 bits wide.
  - The extra MSB is the wrap flag.
  - empty: pointers are fully equal.
  - full: MSBs differ and the low bits are equal.
- s_axis_tready = ~full.
- A write occurs on s_axis_tvalid & s_axis_tready. The FIFO mem is indexed by the low pointer bits.
- Hold register: holds {tlast, nlanes, data}, a lane index lane (0..LANES-1) and a flag hold_v.
- Load: when the FIFO is non-empty and one of the following holds, the head word is copied into the hold register, lane←0, hold_v←1, and the read pointer increments:
  - hold_v=0, or
  - the final-lane handshake happens this cycle (back-to-back, no bubble).
- m_axis_tvalid = hold_v.
- m_axis_tdata = data[lane*OUT_DATA_WIDTH +: OUT_DATA_WIDTH].
- On each m handshake (m_axis_tvalid & m_axis_tready):
  - If lane < nlanes-1: lane increments.
  - Otherwise this is the final lane: load the next word as above, or set hold_v←0 if the FIFO is empty.
- frame_done is combinational: final-lane handshake & held tlast.
- Frame counter: increments by 1 on every m handshake. It resets to 0 on the cycle after frame_done.
- frame_beats = counter + handshake.
- TKEEP with any non-kept lane below a kept lane, or with no lane kept: behaviour undefined. The DMA never produces these.
- A word with tlast=0 and nlanes<LANES is legal. Only its nlanes lanes are emitted.
- Simultaneous write and load: both pointers move, so occupancy is unchanged.
- A write into a full FIFO cannot occur because tready is low. The full flag clears in the cycle after a load.

## Timing

- Reset (rst=1 at a clock edge): both pointers←0, hold_v←0, lane←0, frame counter←0.
- Output values during and after reset:
  - s_axis_tready=1
  - m_axis_tvalid=0
  - m_axis_tdata=0, because the hold data register also resets
  - frame_done=0
  - frame_beats=0
  - occupancy=0
- Reset asserted mid-frame discards all buffered and held data. No frame_done is issued.
- Latency: a word written at edge N (FIFO empty, hold_v=0) is loaded at edge N+1. m_axis_tvalid is high after edge N+1.
- Sustained throughput: one narrow beat per cycle while m_axis_tready=1. DMA-side throughput is 1 word per LANES cycles at steady state.
- m_axis_tvalid never drops without a handshake. m_axis_tdata is stable while tvalid=1 and tready=0.
- With the hold register, total buffering is DEPTH+1 words.

## Test plan

- Reset/idle: assert rst 2 cycles with s_axis_tvalid=1 -> no write occurs. s_axis_tready=1 and m_axis_tvalid=0 throughout, occupancy=0.
- Serialization: write 0x44332211 with tkeep=0xF and tlast=1, m_axis_tready=1 -> m_axis_tdata sequence 0x11,0x22,0x33,0x44 on consecutive cycles, starting 1 cycle after the write. frame_done pulses with 0x44, where frame_beats=4.
- Partial last beat: write 0xAABBCCDD (tkeep=0xF, tlast=0), then 0x00000605 (tkeep=0x3, tlast=1) -> beats DD,CC,BB,AA,05,06 with no bubble. frame_done is on 06 with frame_beats=6.
- Full/backpressure: m_axis_tready=0, write 9 words -> s_axis_tready falls after the 9th accepted word (DEPTH=8 plus the hold register), with occupancy=8. Then release tready -> all 36 bytes arrive in order and s_axis_tready rises one cycle after the first load.
- Pointer wrap: stream 3 frames of 5 words each with random tready stalls -> byte order is intact across the pointer wrap. Exactly 3 frame_done pulses, each with frame_beats=20.
- Mid-frame reset: reset after 2 of 4 lanes are emitted -> m_axis_tvalid=0 and no frame_done. A following frame starts at lane 0 with frame_beats=1 on its first beat.
